// File: rtl/arbiter_wrr_grant_control_pkg.sv
// Shared types and helpers for the weighted round-robin grant scheduler.
// The optional per-requester beat counters are enabled by ARBITER_WRR_STATS_EN.
package arbiter_wrr_grant_control_pkg;

  localparam int unsigned ARBITER_WRR_STATS_WIDTH = 16;

  typedef logic [1:0] arbiter_wrr_state_t;

  localparam arbiter_wrr_state_t StIdle  = 2'd0;
  localparam arbiter_wrr_state_t StHold  = 2'd1;
  localparam arbiter_wrr_state_t StStall = 2'd2;

  // A zero weight still has to grant something, so it behaves as one pop.
  function automatic int unsigned weight_or_one(input int unsigned weight);
    return (weight == 0) ? 1 : weight;
  endfunction

endpackage

// File: rtl/arbiter_wrr_grant_control_rr_next_index_picker.sv
// Combinational round-robin picker: first requesting index strictly after the pointer,
// wrapping, with the pointer's own index considered last.
module arbiter_wrr_grant_control_rr_next_index_picker #(
  parameter int unsigned NUM_REQUESTOR = 4
) (
  input  logic [NUM_REQUESTOR-1:0]         req_i,
  input  logic [$clog2(NUM_REQUESTOR)-1:0] ptr_i,
  output logic [NUM_REQUESTOR-1:0]         onehot_o,
  output logic [$clog2(NUM_REQUESTOR)-1:0] idx_o,
  output logic                             found_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQUESTOR);

  logic [IdxW-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQUESTOR; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NUM_REQUESTOR);
      if (!found_o && req_i[cand]) begin
        found_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr_grant_control.sv
// Weighted round-robin grant scheduler sharing one downstream FIFO among N requesters.
// Define ARBITER_WRR_STATS_EN to build the saturating per-requester beat counters.
module arbiter_wrr_grant_control
  import arbiter_wrr_grant_control_pkg::*;
#(
  parameter int unsigned NUM_REQUESTOR  = 4,
  parameter int unsigned BUS_WIDTH      = 64,
  parameter int unsigned WEIGHT_WIDTH   = 4,
  parameter int unsigned DEFAULT_WEIGHT = 1
) (
  input  logic                                               ap_clk,
  input  logic                                               areset,
  input  logic [NUM_REQUESTOR-1:0]                           arbiter_req,
  input  logic [NUM_REQUESTOR-1:0]                           arbiter_bus_valid,
  input  logic [NUM_REQUESTOR-1:0][BUS_WIDTH-1:0]            arbiter_bus_in,
  input  logic                                               downstream_prog_full,
  input  logic [NUM_REQUESTOR*WEIGHT_WIDTH-1:0]              cfg_weight_in,
  input  logic                                               cfg_weight_valid,
  output logic [NUM_REQUESTOR-1:0]                           arbiter_grant,
  output logic                                               arbiter_bus_out_valid,
  output logic [BUS_WIDTH-1:0]                               arbiter_bus_out,
  output logic                                               arbiter_idle_out,
  output logic [NUM_REQUESTOR*ARBITER_WRR_STATS_WIDTH-1:0]   arbiter_stats_out
);

  localparam int unsigned IdxW = $clog2(NUM_REQUESTOR);

  arbiter_wrr_state_t                         state_q, state_d;
  logic [IdxW-1:0]                            ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0]                    quota_q, quota_d;
  logic [NUM_REQUESTOR-1:0]                   grant_q, grant_d;
  logic [NUM_REQUESTOR-1:0]                   grant_d1_q;
  logic                                       out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0]                       out_q, out_d;
  logic [NUM_REQUESTOR-1:0][WEIGHT_WIDTH-1:0] weights_q, weights_d;

  logic [NUM_REQUESTOR-1:0] pick_onehot;
  logic [IdxW-1:0]          pick_idx;
  logic                     pick_found;
  logic [WEIGHT_WIDTH-1:0]  pick_quota;
  logic                     owner_req, pop, take_pick, go_idle;

  // ptr_q always names the current owner once a grant has been issued.
  arbiter_wrr_grant_control_rr_next_index_picker #(
    .NUM_REQUESTOR (NUM_REQUESTOR)
  ) u_picker (
    .req_i    (arbiter_req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  always_comb begin
    owner_req  = arbiter_req[ptr_q];
    pop        = grant_q[ptr_q] & owner_req;
    pick_quota = WEIGHT_WIDTH'(weight_or_one(32'(weights_q[pick_idx])));
    state_d    = state_q;
    ptr_d      = ptr_q;
    quota_d    = quota_q;
    grant_d    = grant_q;
    take_pick  = 1'b0;
    go_idle    = 1'b0;
    case (state_q)
      StIdle: begin
        grant_d   = '0;
        take_pick = ~downstream_prog_full & pick_found;
      end
      StHold: begin
        if (downstream_prog_full) begin
          // The pop already issued this cycle still consumes quota.
          grant_d = '0;
          state_d = StStall;
          if (pop && quota_q != '0) quota_d = quota_q - 1'b1;
        end else if ((pop && quota_q == WEIGHT_WIDTH'(1)) || !owner_req) begin
          take_pick = pick_found;
          go_idle   = ~pick_found;
        end else if (pop && quota_q != '0) begin
          quota_d = quota_q - 1'b1;
        end
      end
      StStall: begin
        if (!downstream_prog_full) begin
          if (owner_req && quota_q != '0) begin
            grant_d = NUM_REQUESTOR'(1) << ptr_q;
            state_d = StHold;
          end else begin
            take_pick = pick_found;
            go_idle   = ~pick_found;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (take_pick) begin
      grant_d = pick_onehot;
      ptr_d   = pick_idx;
      quota_d = pick_quota;
      state_d = StHold;
    end
    if (go_idle) begin
      grant_d = '0;
      state_d = StIdle;
    end
  end

  always_comb begin
    weights_d   = cfg_weight_valid ? cfg_weight_in : weights_q;
    out_valid_d = |(arbiter_bus_valid & grant_d1_q);
    out_d       = out_q;
    for (int unsigned i = 0; i < NUM_REQUESTOR; i++) begin
      if (grant_d1_q[i]) out_d = arbiter_bus_in[i];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(NUM_REQUESTOR - 1);
      quota_q     <= '0;
      grant_q     <= '0;
      grant_d1_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      weights_q   <= {NUM_REQUESTOR{WEIGHT_WIDTH'(DEFAULT_WEIGHT)}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      quota_q     <= quota_d;
      grant_q     <= grant_d;
      grant_d1_q  <= grant_q;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      weights_q   <= weights_d;
    end
  end

  assign arbiter_grant         = grant_q;
  assign arbiter_bus_out_valid = out_valid_q;
  assign arbiter_bus_out       = out_q;
  assign arbiter_idle_out      = (state_q == StIdle) & ~|grant_d1_q & ~out_valid_q;

`ifdef ARBITER_WRR_STATS_EN
  logic [NUM_REQUESTOR-1:0][ARBITER_WRR_STATS_WIDTH-1:0] stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    for (int unsigned i = 0; i < NUM_REQUESTOR; i++) begin
      if (grant_d1_q[i] && arbiter_bus_valid[i] && stats_q[i] != '1) begin
        stats_d[i] = stats_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) stats_q <= '0;
    else        stats_q <= stats_d;
  end

  assign arbiter_stats_out = stats_q;
`else
  assign arbiter_stats_out = '0;
`endif

endmodule

// File: doc/arbiter_wrr_grant_control.md
Name: arbiter_wrr_grant_control

Overview:
Weighted round-robin grant scheduler that shares one downstream request FIFO among N requester FIFOs. It is a drop-in alternative to the plain round-robin bus arbiter inside the N-to-1 request/response control blocks. Each grant lasts a configurable number of pops (weight) per requester. Grants are withheld while the downstream FIFO reports prog_full. The granted beat is muxed onto a single registered output bus.

Parameters:
NUM_REQUESTOR, 4, number of requester ports (≥2).
BUS_WIDTH, 64, width of each bus word (normally $bits(ControlPacket)).
WEIGHT_WIDTH, 4, bits per requester weight.
DEFAULT_WEIGHT, 1, weight loaded at reset for every requester.

Ports:
ap_clk  in  1  clock; everything is synchronous to its rising edge.
areset  in  1  synchronous, active-high reset.
arbiter_req  in  NUM_REQUESTOR  requester i has data (i.e. ~fifo.empty).
arbiter_bus_valid  in  NUM_REQUESTOR  requester i popped word is valid (1 cycle after pop).
arbiter_bus_in  in  NUM_REQUESTOR x BUS_WIDTH  requester data words.
downstream_prog_full  in  1  downstream FIFO prog_full.
cfg_weight_in  in  NUM_REQUESTOR*WEIGHT_WIDTH  new weights; slice i belongs to requester i.
cfg_weight_valid  in  1  latch cfg_weight_in.
arbiter_grant  out  NUM_REQUESTOR  registered one-hot (or zero) pop enable.
arbiter_bus_out_valid  out  1  registered output valid.
arbiter_bus_out  out  BUS_WIDTH  registered output word.
arbiter_idle_out  out  1  FSM in IDLE and no beat in flight.
arbiter_stats_out  out  NUM_REQUESTOR*16  per-requester beat counters (optional feature).

Behaviour:
- Reset values:
  - arbiter_grant = 0; arbiter_bus_out_valid = 0; arbiter_bus_out = 0; arbiter_idle_out = 1; arbiter_stats_out = 0.
  - Weights = DEFAULT_WEIGHT; rr_pointer = NUM_REQUESTOR-1; quota = 0; state = IDLE.
- State IDLE:
  - Entry condition: a requester is pending when |arbiter_req and ~downstream_prog_full.
  - On the next edge: owner = first requesting index strictly after rr_pointer (wrapping N-1→0).
  - Grant owner's bit; quota = weight[owner] (weight 0 treated as 1); rr_pointer = owner; go to HOLD.
- State HOLD:
  - Each cycle with arbiter_grant[owner] & arbiter_req[owner] counts as one pop; quota decrements.
  - Release conditions: pop with quota==1, or arbiter_req[owner]==0.
    - Another requester pending: switch grant directly to the next RR index (no bubble) and reload quota.
    - Otherwise: grant=0, go to IDLE.
  - Owner is sole requester with quota exhausted: it is re-granted with a fresh quota.
  - downstream_prog_full==1: grant=0 next edge, quota preserved, go to STALL.
  - prog_full takes priority over release on the same cycle.
- State STALL:
  - Stay while prog_full==1.
  - On deassertion:
    - Owner still requesting: re-grant owner with preserved quota, go to HOLD.
    - Else: pick next RR requester (→HOLD) or go to IDLE.
- Pop accounting: grant is a registered pop enable, so a pop issued on a cycle with arbiter_req[owner]==0 is not counted.
- Data path:
  - grant_d1 = arbiter_grant delayed 1 cycle.
  - arbiter_bus_out_valid <= |(arbiter_bus_valid & grant_d1).
  - arbiter_bus_out <= word of the grant_d1 index.
  - Latency: grant edge → valid returns +1 → output +1.
  - Words in flight after a grant drop or switch are still forwarded; none are dropped.
  - Valid from a non-grant_d1 index is ignored.
- Config:
  - cfg_weight_valid latches all weights in one cycle.
  - The current quota is unaffected; new weights apply at the next quota load.
  - Config during reset is ignored.
- Quota counter is WEIGHT_WIDTH bits wide and never underflows.
- Reset mid-HOLD: grant drops the next edge; in-flight data is discarded (output valid=0).
- arbiter_idle_out = (state==IDLE) & ~|grant_d1 & ~arbiter_bus_out_valid.

Optional Feature:
ARBITER_WRR_STATS_EN
- Defined: per-requester 16-bit saturating counter increments on each forwarded beat attributed to that requester. Counters are cleared by areset and stick at 0xFFFF.
- Undefined: arbiter_stats_out is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package:
  - ArbiterWrrState enum {IDLE, HOLD, STALL}.
  - ARBITER_WRR_STATS_WIDTH = 16.
  - Helper function weight_or_one().
- Sub-module rr_next_index_picker (combinational, parameterised): from request vector and pointer, returns next one-hot index and a found flag.
- Instantiated once; also used on the STALL exit path.

Test Plan:
1. Reset → all outputs at reset values, idle_out=1. Then req=4'b0001 → grant=0001 one edge later.
2. Weights {3,1,1,1}, req=4'b0011 continuously → grant sequence 0001,0001,0001,0010,0001,0001,0001,0010…
3. Owner 0 granted; assert prog_full for 5 cycles after its 1st of 3 pops → grant 0 for 5 cycles, then resumes owner 0 with exactly 2 more pops.
4. Switch 0→1 while a word from requester 0 is in flight → output shows the req0 word then the req1 word; no drops or duplicates.
5. Weight 0 on requester 2, sole requester → one pop per grant, re-granted continuously; cfg write of weights mid-HOLD does not change the current quota.
6. With ARBITER_WRR_STATS_EN: 70000 beats from requester 1 → its stats slice = 0xFFFF, others 0. Without the macro → stats = 0.
